// File: rtl/argmax_finder_pkg.sv
// Shared MLP definitions: FSM state encoding, index-width helper and the
// default layer geometry used by argmax_finder and the layer modules.
package argmax_finder_pkg;

  localparam int NN_DEFAULT     = 10;
  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for n elements; never narrower than one bit so NN=1 still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_finder_if.sv
// Capture/result bundle between the final neuron layer and argmax_finder.
// master = layer/consumer side, slave = the argmax engine.
interface argmax_finder_if
  import argmax_finder_pkg::*;
#(
  parameter int NN        = NN_DEFAULT,
  parameter int dataWidth = DATA_W_DEFAULT,
  parameter int IDX_W     = idx_width(NN)
);

  logic [NN*dataWidth-1:0] i_data;
  logic                    i_valid;
  logic                    i_ready;
  logic [IDX_W-1:0]        o_index;
  logic [dataWidth-1:0]    o_max;
  logic                    o_valid;
  logic                    o_overrun;

  modport master (
    output i_data, i_valid,
    input  i_ready, o_index, o_max, o_valid, o_overrun
  );

  modport slave (
    input  i_data, i_valid,
    output i_ready, o_index, o_max, o_valid, o_overrun
  );

endinterface

// File: rtl/argmax_finder_cmp.sv
// Strict-greater comparator for the argmax scan. Define ARGMAX_SIGNED_EN for
// two's-complement elements; otherwise the compare is unsigned.
module argmax_cmp #(
  parameter int dataWidth = 16
) (
  input  logic [dataWidth-1:0] cand,
  input  logic [dataWidth-1:0] cur_max,
  output logic                 greater
);

`ifdef ARGMAX_SIGNED_EN
  assign greater = $signed(cand) > $signed(cur_max);
`else
  assign greater = cand > cur_max;
`endif

endmodule

// File: rtl/argmax_finder.sv
// Captures NN neuron outputs in one cycle, scans them one per cycle and reports
// the lowest index of the maximum. Signedness is selected by ARGMAX_SIGNED_EN.
module argmax_finder
  import argmax_finder_pkg::*;
#(
  parameter int NN        = NN_DEFAULT,
  parameter int dataWidth = DATA_W_DEFAULT,
  parameter int IDX_W     = idx_width(NN)
) (
  input logic            clk,
  input logic            rst,
  argmax_finder_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     run_idx_reg, run_idx_next;
  logic [dataWidth-1:0] run_max_reg, run_max_next;
  logic [IDX_W-1:0]     o_index_reg, o_index_next;
  logic [dataWidth-1:0] o_max_reg, o_max_next;
  logic                 overrun_reg, overrun_next;
  logic                 capture;

  logic [dataWidth-1:0] buf_reg [NN];
  logic [dataWidth-1:0] data_in [NN];
  logic [dataWidth-1:0] cand;
  logic                 cand_gt;

  for (genvar gi = 0; gi < NN; gi++) begin : gen_unpack
    assign data_in[gi] = bus.i_data[gi*dataWidth +: dataWidth];
  end

  assign cand = buf_reg[cnt_reg];

  argmax_cmp #(.dataWidth(dataWidth)) u_cmp (
    .cand    (cand),
    .cur_max (run_max_reg),
    .greater (cand_gt)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    run_idx_next = run_idx_reg;
    run_max_next = run_max_reg;
    o_index_next = o_index_reg;
    o_max_next   = o_max_reg;
    overrun_next = overrun_reg;
    capture      = 1'b0;

    unique case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.i_valid) begin
          capture      = 1'b1;
          run_max_next = data_in[0];
          run_idx_next = '0;
          cnt_next     = ONE_IDX;
          if (NN == 1) begin
            // A single element is its own maximum: skip the scan entirely.
            state_next   = DONE;
            o_index_next = '0;
            o_max_next   = data_in[0];
          end else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (bus.i_valid) overrun_next = 1'b1;
        if (cand_gt) begin
          run_max_next = cand;
          run_idx_next = cnt_reg;
        end
        if (cnt_reg == LAST_IDX) begin
          state_next   = DONE;
          o_index_next = cand_gt ? cnt_reg : run_idx_reg;
          o_max_next   = cand_gt ? cand : run_max_reg;
        end else begin
          cnt_next = cnt_reg + ONE_IDX;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      run_idx_reg <= '0;
      run_max_reg <= '0;
      o_index_reg <= '0;
      o_max_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      run_idx_reg <= run_idx_next;
      run_max_reg <= run_max_next;
      o_index_reg <= o_index_next;
      o_max_reg   <= o_max_next;
      overrun_reg <= overrun_next;
    end
  end

  // The buffer decouples the scan from i_data so the layer may move on at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NN; k++) buf_reg[k] <= '0;
    end else if (capture) begin
      buf_reg <= data_in;
    end
  end

  assign bus.i_ready   = (state_reg != SCAN);
  assign bus.o_valid   = (state_reg == DONE);
  assign bus.o_index   = o_index_reg;
  assign bus.o_max     = o_max_reg;
  assign bus.o_overrun = overrun_reg;

endmodule

// File: tb/tb_argmax_finder.sv
// Randomised scoreboard bench for argmax_finder: the driver pushes expected
// results from a reference model, an independent monitor pops and compares.
module tb_argmax_finder;
  import argmax_finder_pkg::*;

  localparam int NN = 10;
  localparam int DW = 16;
  localparam int IW = idx_width(NN);

  typedef struct {
    int            idx;
    logic [DW-1:0] mx;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  exp_t sb[$];
  int   last_acc = 0;
  bit   have_acc = 0;
  bit   overrun_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  argmax_finder_if #(.NN(NN), .dataWidth(DW), .IDX_W(IW)) bus ();

  argmax_finder #(.NN(NN), .dataWidth(DW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Find the maximum value, then the first position that holds it.
  function automatic void ref_argmax(input logic [NN*DW-1:0] v, output int idx,
                                     output logic [DW-1:0] mx);
    logic [DW-1:0] e;
    mx = v[DW-1:0];
    for (int k = 1; k < NN; k++) begin
      e = v[k*DW +: DW];
      if (gt(e, mx)) mx = e;
    end
    idx = -1;
    for (int k = NN - 1; k >= 0; k--) if (v[k*DW +: DW] == mx) idx = k;
  endfunction

  task automatic wait_period(input int p);
    while (cyc < p) @(negedge clk);
  endtask

  // Called on a negedge; holds i_valid for exactly one rising edge.
  task automatic strobe(input logic [NN*DW-1:0] v);
    exp_t e;
    bit   acc;
    int   p;
    p   = cyc;
    acc = !(have_acc && p > last_acc && p < last_acc + NN);
    check("i_ready", bus.i_ready, acc);
    bus.i_data  = v;
    bus.i_valid = 1'b1;
    if (acc) begin
      ref_argmax(v, e.idx, e.mx);
      e.due = p + NN;
      sb.push_back(e);
      last_acc = p;
      have_acc = 1;
      $display("strobe cycle %0d accepted: expect index %0d max %04h at cycle %0d",
               p, e.idx, e.mx, e.due);
    end else begin
      overrun_exp = 1;
      $display("strobe cycle %0d dropped (busy)", p);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = ~v;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (!rst) begin
      check("o_overrun", bus.o_overrun, overrun_exp);
      if (sb.size() > 0 && cyc > sb[0].due) begin
        n_vec++;
        n_bad++;
        $display("FAIL o_valid_missing: no pulse by cycle %0d, required at cycle %0d",
                 cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (bus.o_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL o_valid_unexpected: pulse at cycle %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          $display("result cycle %0d: index %0d max %04h", cyc, bus.o_index, bus.o_max);
          check("o_valid_cycle", 64'(cyc), 64'(e.due));
          check("o_index", 64'(bus.o_index), 64'(e.idx));
          check("o_max", 64'(bus.o_max), 64'(e.mx));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [NN*DW-1:0] v, w;
    logic [NN*DW-1:0] v_idx7;

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    #2;
    check("reset_o_index", 64'(bus.o_index), 64'd0);
    check("reset_o_max", 64'(bus.o_max), 64'd0);
    check("reset_o_valid", 64'(bus.o_valid), 64'd0);
    check("reset_o_overrun", 64'(bus.o_overrun), 64'd0);
    check("reset_i_ready", 64'(bus.i_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Maximum at index 7
    for (int k = 0; k < NN; k++) v_idx7[k*DW +: DW] = 16'h0100;
    v_idx7[7*DW +: DW] = 16'h0F00;
    strobe(v_idx7);
    drain();

    // Tie between elements 3 and 8: lowest index wins
    v = '0;
    v[3*DW +: DW] = 16'h7FFF;
    v[8*DW +: DW] = 16'h7FFF;
    strobe(v);
    drain();

    // Sign handling
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = 16'h0001;
    v[2*DW +: DW] = 16'hFF00;
    strobe(v);
    drain();

    // Back-to-back capture in the DONE cycle
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = 16'($urandom);
    for (int k = 0; k < NN; k++) w[k*DW +: DW] = 16'($urandom);
    strobe(v);
    wait_period(last_acc + NN);
    strobe(w);
    drain();

    // Random vectors, half drawn from a tiny range to force ties
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < NN; k++)
        v[k*DW +: DW] = (t % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      wait_period(last_acc + NN + int'($urandom_range(0, 3)));
      strobe(v);
    end
    drain();

    // Overrun: second strobe four cycles into the scan is dropped
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = 16'($urandom);
    w = ~v;
    strobe(v);
    wait_period(last_acc + 4);
    strobe(w);
    drain();
    repeat (3) @(negedge clk);

    // Reset mid-scan aborts the inference and clears the sticky flag
    strobe(v_idx7);
    wait_period(last_acc + 5);
    rst = 1'b1;
    #1;
    check("midrst_o_index", 64'(bus.o_index), 64'd0);
    check("midrst_o_max", 64'(bus.o_max), 64'd0);
    check("midrst_o_valid", 64'(bus.o_valid), 64'd0);
    check("midrst_o_overrun", 64'(bus.o_overrun), 64'd0);
    check("midrst_i_ready", 64'(bus.i_ready), 64'd1);
    sb.delete();
    have_acc    = 0;
    overrun_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (NN + 4) @(negedge clk);

    // Fresh capture after reset
    strobe(v_idx7);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/argmax_finder.md
Name: argmax_finder

Overview:
- Output stage directly downstream of the final 10-neuron layer.
- Captures the layer's NN parallel neuron outputs in one cycle, then scans them sequentially, one element per cycle.
- Reports the index of the largest element (the predicted class), its value, and a one-cycle valid pulse.
- Frees the layer outputs immediately after capture, so the layer can start the next inference.

Parameters:
- NN, 10: number of input elements (neurons in the final layer); legal range NN >= 1.
- dataWidth, 16: width of each element in bits.
- IDX_W, $clog2(NN) (minimum 1): width of the index output.

Ports:
- clk  input  1  sole clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_data  input  NN*dataWidth  packed element vector; element k is i_data[k*dataWidth +: dataWidth].
- i_valid  input  1  capture strobe; driven from neuron 0's outvalid.
- i_ready  output  1  high when a strobe on i_valid will be accepted.
- o_index  output  IDX_W  index of the maximum element.
- o_max  output  dataWidth  value of the maximum element.
- o_valid  output  1  one-cycle pulse; o_index and o_max are valid while it is high.
- o_overrun  output  1  sticky flag: a strobe arrived while busy and was dropped.

Behaviour:
- Reset values: o_index=0, o_max=0, o_valid=0, o_overrun=0, i_ready=1, state=IDLE, scan counter=0, capture buffer=0.
- States: IDLE, SCAN, DONE.
- i_ready = (state != SCAN).
- IDLE or DONE with i_valid=1:
  - Register all NN elements into the buffer.
  - Set running max = element 0, running index = 0, counter = 1.
  - Next state SCAN; if NN==1, next state DONE.
- SCAN, each cycle:
  - Compare buffer[counter] against the running max.
  - If strictly greater, update running max and index.
  - Increment counter.
  - When counter==NN-1, apply the final compare and go to DONE.
- DONE:
  - o_valid=1 for exactly this cycle; o_index and o_max are registered.
  - Next state IDLE, unless i_valid=1, which performs a back-to-back capture into SCAN.
- Outside DONE: o_valid=0; o_index and o_max hold their last results.
- Latency: i_valid sampled at cycle 0 → o_valid high in cycle NN (cycle 1 for NN=1).
- Throughput: one result per NN cycles.
- Ties: the lowest index wins (strict-greater compare).
- i_valid during SCAN:
  - The strobe is dropped and the buffer is untouched.
  - o_overrun is set and stays set until rst.
- i_data is sampled only on an accepted capture; later changes on i_data do not affect an in-flight scan.
- rst asserted mid-scan: immediate return to reset values; no o_valid is produced for the aborted inference.
- Counter width is IDX_W; it never wraps, since it is bounded by NN-1.

Optional Feature:
- Macro: ARGMAX_SIGNED_EN.
- Defined: elements and o_max are treated as two's-complement signed; compare is signed (for ReLU or raw-score layers).
- Undefined: unsigned compare (sigmoid outputs are non-negative).
- The choice affects only the comparator; timing and the interface are identical either way.

Decomposition:
- Shared MLP package/header holds:
  - state encodings (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - clog2-based width helper used for IDX_W;
  - default dataWidth=16 and NN=10 constants shared with the layer modules.
- One sub-module: argmax_cmp.
  - Purely combinational comparator: candidate, current max → greater flag.
  - Holds the ARGMAX_SIGNED_EN switch so the signedness decision lives in one place.
- FSM, counter and buffer stay in argmax_finder.

Test Plan:
- Max at index 7 (elements 0x0100 except element 7=0x0F00), i_valid at cycle 0 → o_valid only in cycle 10, o_index=7, o_max=0x0F00.
- Tie: elements 3 and 8 both 0x7FFF, others 0 → o_index=3.
- Overrun: second i_valid at cycle 4 with different data → first result unchanged (correct index), o_overrun=1 and remains 1.
- Back-to-back: i_valid again in cycle 10 (the DONE cycle) → accepted; second o_valid in cycle 20 with the second vector's argmax.
- Reset mid-scan: rst at cycle 5 → outputs 0 immediately, no o_valid; a fresh capture afterwards gives the correct result.
- Sign handling: element 2=0xFF00, all others 0x0001.
  - With ARGMAX_SIGNED_EN: o_index=0.
  - Without it: o_index=2, o_max=0xFF00.
